display_scan_mux: RTL and testbench

Time-multiplexed scan driver for a 4-digit common-anode 7-segment display. It sits directly upstream of the single-digit 7-segment decoder. It holds a 16-bit, 4-nibble display value and cycles through the digits at a prescaled rate. On each step it drives one active-low anode enable and presents that digit's nibble on `val` for the decoder. Loads are double-buffered so a new value only becomes visible at a frame boundary, which prevents a torn display.

---
 rtl/display_pkg.sv | 23 ++
 rtl/tick_gen.sv | 34 +++
 rtl/display_scan_mux.sv | 113 +++++++++++
 tb/tb_display_scan_mux.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  display_pkg
//  Shared constants, digit index type and helpers for the display scan blocks.
//  Revision: 1.0
// ============================================================================
package display_pkg;
    localparam int         N_DIGITS         = 4;
    localparam logic [3:0] AN_OFF           = 4'b1111;
    localparam int         DEFAULT_PRESCALE = 50000;

    typedef logic [1:0] digit_idx_t;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [3:0] an_onehot_low(input digit_idx_t idx);
        an_onehot_low = ~(4'b0001 << idx);
    endfunction

    function automatic logic [3:0] nibble_at(input logic [15:0] v, input digit_idx_t idx);
        nibble_at = v[{idx, 2'b00} +: 4];
    endfunction
endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  tick_gen
//  Free-running prescaler; tick_o is high for one cycle every PRESCALE cycles.
//  Revision: 1.0
// ============================================================================
module tick_gen #(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = $clog2(PRESCALE + 1)
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
//  display_scan_mux
//  4-digit common-anode scan driver with frame-synchronous double-buffered load.
//  Revision: 1.0
// ============================================================================
module display_scan_mux
    import display_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int CNT_W    = $clog2(PRESCALE + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        blank,
    input  logic        lzb_en,
    output logic [3:0]  val,
    output logic [3:0]  an,
    output logic        frame_done
);
    localparam digit_idx_t C_LAST_IDX = digit_idx_t'(N_DIGITS - 1);

    logic        w_tick;
    logic        w_wrap;
    digit_idx_t  idx_q, idx_d;
    logic [15:0] active_q, active_d;
    logic [15:0] pending_q, pending_d;
    logic        pending_valid_q, pending_valid_d;
    logic        frame_done_q, frame_done_d;
    logic [3:0]  val_q, val_d;
    logic [3:0]  an_q, an_d;
    logic        blank_q;
    logic [3:0]  w_lz_vec;
    logic        w_lz_blanked;
    logic [3:0]  w_an_new;

    tick_gen #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .tick_o (w_tick)
    );

    assign w_wrap = w_tick && (idx_q == C_LAST_IDX);

    always_comb begin
        idx_d           = w_tick ? idx_q + 2'd1 : idx_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        frame_done_d    = 1'b0;
        if (w_wrap && load) begin
            // Load on the wrap edge skips the buffer and shows immediately.
            active_d        = data_in;
            pending_valid_d = 1'b0;
            frame_done_d    = 1'b1;
        end else if (w_wrap && pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
            frame_done_d    = 1'b1;
        end else if (load) begin
            pending_d       = data_in;
            pending_valid_d = 1'b1;
        end
    end

    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 never is.
    always_comb begin
        w_lz_vec[3] = (active_d[15:12] == 4'h0);
        w_lz_vec[2] = w_lz_vec[3] && (active_d[11:8] == 4'h0);
        w_lz_vec[1] = w_lz_vec[2] && (active_d[7:4] == 4'h0);
        w_lz_vec[0] = 1'b0;
        w_lz_blanked = lzb_en && w_lz_vec[idx_d];
        w_an_new     = (blank || w_lz_blanked) ? AN_OFF : an_onehot_low(idx_d);
    end

    // Anodes refresh on a digit step or whenever blank changes level.
    always_comb begin
        val_d = w_tick ? nibble_at(active_d, idx_d) : val_q;
        an_d  = (w_tick || (blank != blank_q)) ? w_an_new : an_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q           <= '0;
            active_q        <= 16'h0000;
            pending_q       <= 16'h0000;
            pending_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            val_q           <= 4'b0000;
            an_q            <= AN_OFF;
            blank_q         <= 1'b0;
        end else begin
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            frame_done_q    <= frame_done_d;
            val_q           <= val_d;
            an_q            <= an_d;
            blank_q         <= blank;
        end
    end

    assign val        = val_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================================
//  tb_display_scan_mux
//  Directed self-checking bench for display_scan_mux with PRESCALE=4.
//  Revision: 1.0
// ============================================================================
module tb_display_scan_mux;
    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        load;
    logic        blank;
    logic        lzb_en;
    logic [3:0]  val;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int e        = 0;

    display_scan_mux #(.PRESCALE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load       (load),
        .blank      (blank),
        .lzb_en     (lzb_en),
        .val        (val),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after edge k counted from the last reset release.
    task automatic goto(input int k);
        repeat (k - e) @(posedge clk);
        #1;
        e = k;
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp_an, input logic [3:0] exp_val);
        chk4({tag, "_an"}, an, exp_an);
        chk4({tag, "_val"}, val, exp_val);
    endtask

    task automatic chk_fd(input string tag, input logic exp);
        chk4({tag, "_fd"}, {3'b000, frame_done}, {3'b000, exp});
    endtask

    task automatic do_load(input int k, input logic [15:0] d);
        goto(k - 1);
        load    = 1'b1;
        data_in = d;
        goto(k);
        load    = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 16'h0000;
        load    = 1'b0;
        blank   = 1'b0;
        lzb_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("rst", 4'b1111, 4'b0000);
        chk_fd("rst", 1'b0);
        reset = 1'b0;
        e     = 0;

        // 1: idle scan, edges at multiples of 4 step the digit
        goto(3);   chk_out("t1_e3", 4'b1111, 4'h0);
        goto(4);   chk_out("t1_e4", 4'b1101, 4'h0);
        goto(7);   chk_out("t1_e7", 4'b1101, 4'h0);
        goto(8);   chk_out("t1_e8", 4'b1011, 4'h0);
        goto(12);  chk_out("t1_e12", 4'b0111, 4'h0);
        goto(16);  chk_out("t1_e16", 4'b1110, 4'h0); chk_fd("t1_e16", 1'b0);
        goto(17);  chk_fd("t1_e17", 1'b0);

        // 2: load mid-frame, visible only after the next wrap
        do_load(19, 16'h1234);
        goto(20);  chk_out("t2_e20", 4'b1101, 4'h0);
        goto(31);  chk_fd("t2_e31", 1'b0); chk_out("t2_e31", 4'b0111, 4'h0);
        goto(32);  chk_out("t2_e32", 4'b1110, 4'h4); chk_fd("t2_e32", 1'b1);
        goto(33);  chk_fd("t2_e33", 1'b0);
        goto(36);  chk_out("t2_e36", 4'b1101, 4'h3);
        goto(40);  chk_out("t2_e40", 4'b1011, 4'h2);
        goto(44);  chk_out("t2_e44", 4'b0111, 4'h1);

        // 3: leading-zero blanking
        lzb_en = 1'b1;
        do_load(46, 16'h0050);
        goto(48);  chk_out("t3_e48", 4'b1110, 4'h0); chk_fd("t3_e48", 1'b1);
        goto(52);  chk_out("t3_e52", 4'b1101, 4'h5);
        goto(56);  chk_out("t3_e56", 4'b1111, 4'h0);
        goto(60);  chk_out("t3_e60", 4'b1111, 4'h0);
        do_load(61, 16'h0000);
        goto(64);  chk_out("t3_e64", 4'b1110, 4'h0); chk_fd("t3_e64", 1'b1);
        goto(68);  chk_out("t3_e68", 4'b1111, 4'h0);
        goto(72);  chk_out("t3_e72", 4'b1111, 4'h0);
        goto(76);  chk_out("t3_e76", 4'b1111, 4'h0);
        lzb_en = 1'b0;

        // 4: last write wins, hex nibble F passes through
        do_load(77, 16'hAAAA);
        do_load(79, 16'h9F01);
        goto(80);  chk_out("t4_e80", 4'b1110, 4'h1); chk_fd("t4_e80", 1'b1);
        goto(81);  chk_fd("t4_e81", 1'b0);
        goto(84);  chk_out("t4_e84", 4'b1101, 4'h0);
        goto(88);  chk_out("t4_e88", 4'b1011, 4'hF);
        goto(92);  chk_out("t4_e92", 4'b0111, 4'h9);
        goto(96);  chk_out("t4_e96", 4'b1110, 4'h1); chk_fd("t4_e96", 1'b0);

        // 5: load on the wrap tick bypasses straight to the display
        do_load(112, 16'h4321);
        chk_out("t5_e112", 4'b1110, 4'h1); chk_fd("t5_e112", 1'b1);
        goto(113); chk_fd("t5_e113", 1'b0);
        goto(116); chk_out("t5_e116", 4'b1101, 4'h2);
        goto(128); chk_out("t5_e128", 4'b1110, 4'h1); chk_fd("t5_e128", 1'b0);

        // 6: blank for 10 edges while scanning continues, then async reset
        goto(130); blank = 1'b1;
        goto(131); chk4("t6_e131_an", an, 4'b1111);
        goto(133); chk_out("t6_e133", 4'b1111, 4'h2);
        goto(140); chk_out("t6_e140", 4'b1111, 4'h4);
        blank = 1'b0;
        goto(141); chk_out("t6_e141", 4'b0111, 4'h4);
        goto(143);
        reset = 1'b1;
        #2;
        chk_out("t6_async", 4'b1111, 4'h0);
        chk_fd("t6_async", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        e     = 0;
        goto(3);   chk_out("t6_r3", 4'b1111, 4'h0);
        goto(4);   chk_out("t6_r4", 4'b1101, 4'h0);
        goto(16);  chk_out("t6_r16", 4'b1110, 4'h0); chk_fd("t6_r16", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
